// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory and buffers returned words in a 2-entry queue ahead of decode.
module fetch_unit #(
  parameter int                           INSTRUCTION_WIDTH = 32,
  parameter logic [INSTRUCTION_WIDTH-1:0] RESET_PC          = 32'h0000_0000,
  parameter int                           PC_STEP           = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [INSTRUCTION_WIDTH-1:0] imem_address,
  output logic                         imem_en,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_instruction,
  input  logic                         stall,
  input  logic                         redirect,
  input  logic [INSTRUCTION_WIDTH-1:0] redirect_target,
  output logic                         id_valid,
  output logic [INSTRUCTION_WIDTH-1:0] id_instruction,
  output logic [INSTRUCTION_WIDTH-1:0] id_pc
);

  localparam int            W          = INSTRUCTION_WIDTH;
  localparam logic [W-1:0]  PC_INC     = W'(PC_STEP);
  localparam logic [W-1:0]  ALIGN_MASK = ~(W'(2'b11));

  logic [W-1:0] pc_r;
  logic [W-1:0] req_pc_r;
  logic         inflight_r;
  logic [1:0]   count_r;
  logic [W-1:0] head_ins_r;
  logic [W-1:0] head_pc_r;
  logic [W-1:0] tail_ins_r;
  logic [W-1:0] tail_pc_r;

  logic         pop_s;
  logic         push_s;
  logic         issue_s;
  logic [2:0]   occupancy_s;

  // Credit-based issue: only fetch when the response is guaranteed a queue slot.
  always_comb begin
    pop_s       = 1'b0;
    push_s      = 1'b0;
    issue_s     = 1'b0;
    occupancy_s = 3'd0;
    pop_s       = (count_r != 2'd0) & ~stall & ~redirect;
    push_s      = inflight_r & ~redirect;
    occupancy_s = {1'b0, count_r} + {2'b00, inflight_r};
    if (reset || redirect) begin
      issue_s = 1'b0;
    end else begin
      issue_s = (occupancy_s <= (3'd1 + {2'b00, pop_s}));
    end
  end

  // PC, in-flight tag and queue state; redirect flushes everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      req_pc_r   <= RESET_PC;
      inflight_r <= 1'b0;
      count_r    <= 2'd0;
      head_ins_r <= '0;
      head_pc_r  <= '0;
      tail_ins_r <= '0;
      tail_pc_r  <= '0;
    end else if (redirect) begin
      pc_r       <= redirect_target & ALIGN_MASK;
      inflight_r <= 1'b0;
      count_r    <= 2'd0;
    end else begin
      if (issue_s) begin
        pc_r       <= pc_r + PC_INC;
        req_pc_r   <= pc_r;
        inflight_r <= 1'b1;
      end else begin
        inflight_r <= 1'b0;
      end
      // Head always holds the oldest entry; the tail slot is used only at count 2.
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_ins_r <= imem_instruction;
            head_pc_r  <= req_pc_r;
          end else begin
            tail_ins_r <= imem_instruction;
            tail_pc_r  <= req_pc_r;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          if (count_r == 2'd2) begin
            head_ins_r <= tail_ins_r;
            head_pc_r  <= tail_pc_r;
          end
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            head_ins_r <= imem_instruction;
            head_pc_r  <= req_pc_r;
          end else begin
            head_ins_r <= tail_ins_r;
            head_pc_r  <= tail_pc_r;
            tail_ins_r <= imem_instruction;
            tail_pc_r  <= req_pc_r;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign imem_address   = pc_r;
  assign imem_en        = issue_s;
  assign id_valid       = (count_r != 2'd0);
  assign id_instruction = head_ins_r;
  assign id_pc          = head_pc_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue-based reference model of the fetch
// stage predicts every decode-facing and memory-facing output each cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_address;
  logic        imem_en;
  logic [31:0] imem_instruction;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;

  int total = 0;
  int bad   = 0;
  logic [31:0] salt;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  bit          m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_pc;

  fetch_unit #(
    .INSTRUCTION_WIDTH(32),
    .RESET_PC(32'h0000_0000),
    .PC_STEP(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_address(imem_address),
    .imem_en(imem_en),
    .imem_instruction(imem_instruction),
    .stall(stall),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .id_valid(id_valid),
    .id_instruction(id_instruction),
    .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + salt;
  endfunction

  // Synchronous instruction memory with one cycle of read latency.
  initial imem_instruction = 32'd0;
  always @(posedge clk) begin
    if (imem_en) imem_instruction <= mem_word(imem_address);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_infl    = 1'b0;
    m_infl_pc = 32'h0000_0000;
    m_pc      = 32'h0000_0000;
  endtask

  // Called at a falling edge: drive inputs, check, advance the model, return at next falling edge.
  task automatic step(input bit st, input bit rd, input logic [31:0] tg);
    int pop_i;
    int occ;
    bit exp_en;
    stall           = st;
    redirect        = rd;
    redirect_target = tg;
    #1;
    pop_i  = (mq.size() != 0 && !st && !rd) ? 1 : 0;
    occ    = mq.size() + (m_infl ? 1 : 0) - pop_i;
    exp_en = !rd && (occ <= 1);
    check_eq("id_valid", {31'd0, id_valid}, {31'd0, mq.size() != 0});
    check_eq("imem_en", {31'd0, imem_en}, {31'd0, exp_en});
    check_eq("imem_address", imem_address, m_pc);
    if (mq.size() != 0) begin
      check_eq("id_pc", id_pc, mq[0].pc);
      check_eq("id_instruction", id_instruction, mq[0].ins);
    end
    @(posedge clk);
    if (rd) begin
      mq.delete();
      m_infl = 1'b0;
      m_pc   = {tg[31:2], 2'b00};
    end else begin
      if (pop_i == 1) void'(mq.pop_front());
      if (m_infl) mq.push_back('{pc: m_infl_pc, ins: mem_word(m_infl_pc)});
      if (exp_en) begin
        m_infl_pc = m_pc;
        m_infl    = 1'b1;
        m_pc      = m_pc + 32'd4;
      end else begin
        m_infl = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_id_valid"}, {31'd0, id_valid}, 32'd0);
    check_eq({tag, "_imem_en"}, {31'd0, imem_en}, 32'd0);
    check_eq({tag, "_imem_address"}, imem_address, 32'h0000_0000);
    check_eq({tag, "_id_pc"}, id_pc, 32'h0000_0000);
    check_eq({tag, "_id_instruction"}, id_instruction, 32'h0000_0000);
  endtask

  initial begin
    reset           = 1'b0;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'd0;
    salt            = $urandom;
    model_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b0;

    // Streaming, then a stall window, then release.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0);

    // Unaligned redirect target gets its low bits cleared.
    step(1'b0, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0);

    // Redirect beats a simultaneous stall.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h0000_0203);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0);

    // PC wrap past the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0);

    // Back-to-back redirects: the last one wins.
    step(1'b0, 1'b1, 32'h0000_0040);
    step(1'b0, 1'b1, 32'h0000_0080);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0);

    // Asynchronous reset with the queue full.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0);
    check_eq("queue_full_before_reset", {31'd0, id_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bit          st;
      bit          rd;
      logic [31:0] tg;
      st = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 8);
      tg = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      step(st, rd, tg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the decode/register-fetch stage.
- Owns the program counter and drives the synchronous instruction memory, which has 1-cycle read latency.
- Buffers returned instructions in a 2-entry queue so that decode stalls never lose a fetched word.
- Accepts a redirect (branch/jump) that flushes all in-flight and buffered work.
- Presents one instruction per cycle with valid/stall flow control to decode.

Parameters:
- INSTRUCTION_WIDTH, 32, width of instruction word and of PC/addresses.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  pipeline clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_address  out  INSTRUCTION_WIDTH  fetch address (registered PC).
- imem_en  out  1  fetch request this cycle; imem returns data next cycle.
- imem_instruction  in  INSTRUCTION_WIDTH  imem read data, valid the cycle after imem_en.
- stall  in  1  from hazard detection unit; 1 means decode does not accept this cycle.
- redirect  in  1  branch/jump taken; one-cycle pulse.
- redirect_target  in  INSTRUCTION_WIDTH  new PC when redirect=1.
- id_valid  out  1  id_instruction/id_pc hold a real instruction.
- id_instruction  out  INSTRUCTION_WIDTH  head-of-queue instruction to decode.
- id_pc  out  INSTRUCTION_WIDTH  PC of id_instruction.

Behaviour:
Reset
- While reset is asserted: pc=RESET_PC, queue empty (count=0), inflight=0, id_valid=0, id_instruction=0, id_pc=0.
- imem_address=RESET_PC and imem_en=0.
- Reset asserted mid-operation discards everything immediately (asynchronous).

Issue logic (combinational, per cycle)
- pop = id_valid & ~stall & ~redirect.
- imem_en = ~reset & ~redirect & (count + inflight - pop <= 1).
- When imem_en=1, on the clock edge: pc <= pc + PC_STEP, inflight <= 1, and the tag register req_pc <= pc. Otherwise inflight <= 0.
- PC wraps modulo 2^INSTRUCTION_WIDTH with no flag.

Response capture
- When inflight=1 and no redirect this cycle: {imem_instruction, req_pc} is written to the queue tail at the clock edge.
- The credit rule guarantees the queue never overflows. Overflow is an assertion failure in verification.

Queue (2-entry FIFO)
- Head drives id_instruction and id_pc. id_valid = (count != 0).
- Push and pop in the same cycle: count unchanged, order preserved.
- When empty, id_instruction and id_pc hold their last values; they are don't-care while id_valid=0.

Redirect (priority over stall and issue)
- At the edge ending cycle N: queue cleared (count=0), inflight <= 0, and any imem response arriving in cycle N is dropped.
- Same edge: pc <= {redirect_target[W-1:2], 2'b00}; low 2 bits are forced to 0.
- Cycle N+1: imem_address = target, imem_en=1. Cycle N+2: response captured. Cycle N+3: id_valid=1 with id_pc = target.
- Redirect in consecutive cycles: the last one wins.

Latency and throughput
- After reset deasserts before cycle 0: cycle 0 issues RESET_PC, cycle 2 first id_valid.
- With stall=0, one instruction per cycle sustained (count=1, inflight=1 steady state).

Stall behaviour
- Stall held k cycles: queue fills to 2, imem_en drops to 0, pc frozen, id outputs stable.
- On stall release: back-to-back delivery resumes with no bubble and no duplicate or skipped PC.

Test Plan:
- Reset release, stall=0, imem returns (addr>>2)+100: id_pc = 0,4,8,12... from cycle 2, one per cycle; id_instruction = 100,101,102....
- Stall held cycles 5-9: id_pc frozen at 12 during cycles 5-9; imem_en=0 once count+inflight=2; after release id_pc = 16,20,24 consecutively, no duplicates.
- Redirect pulse in cycle 6 with target 32'h0000_0103: queued entries and in-flight response are dropped; imem_address=0x100 in cycle 7; id_valid=0 in cycles 7-8; id_pc=0x100 in cycle 9.
- Redirect with stall=1 in the same cycle: redirect wins, queue flushed, id_pc = target 3 cycles later.
- PC wrap: redirect to 32'hFFFF_FFFC → id_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.
- Reset asserted asynchronously mid-stream with queue full: id_valid=0 and imem_address=RESET_PC immediately, before the next clock edge; after release, restarts from RESET_PC as in the first scenario.
